// File: rtl/pwm_capture.sv
// pwm_capture: receive-side PWM measurement block.
// Synchronises an external PWM line, measures its period and high time in
// Clock cycles, and presents the last complete result as byte pairs that
// always change together, along with valid / overrun / overflow status.

module pwm_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       pwm_in,
  input  logic       WE_enable_cap,
  input  logic       WE_disable_cap,
  input  logic       RE_ack,
  output logic [7:0] period_low,
  output logic [7:0] period_high,
  output logic [7:0] impuls_low,
  output logic [7:0] impuls_high,
  output logic       cap_valid,
  output logic       cap_overrun,
  output logic       cap_overflow,
  output logic       cap_busy
);

  // A single-flop synchroniser is never safe, so anything below two is raised to two.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [STAGES-1:0] sync_q;
  logic              s;
  logic              s_d;
  logic              rise;
  logic              fall;

  logic [15:0]       cnt;
  logic [15:0]       hi_tmp;
  logic [15:0]       period_q;
  logic [15:0]       impuls_q;

  logic              at_timeout;
  logic              cnt_clear;
  logic              cnt_load;
  logic              cnt_inc;
  logic              hi_load;
  logic              capture;
  logic              timeout_hit;

  // The last synchroniser stage is the clean copy of the line; s_d is its
  // one-cycle-old value, so the edge detectors see each transition exactly once.
  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // A measurement is abandoned only when the counter is at its limit and the
  // line did not move in this cycle; an edge arriving on the limit still counts.
  assign at_timeout = (cnt == TIMEOUT) && !rise && !fall;

  // Shift pwm_in through the synchroniser chain and keep one delayed copy for edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pwm_in};
      s_d    <= sync_q[STAGES-1];
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: arm, follow the line's edges, fall back on timeout; disable overrides all.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (WE_enable_cap) begin
          state_next = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_next = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          state_next = MEAS_LOW;
        end else if (at_timeout) begin
          state_next = WAIT_RISE;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          state_next = MEAS_HIGH;
        end else if (at_timeout) begin
          state_next = WAIT_RISE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (WE_disable_cap) begin
      state_next = IDLE;
    end
  end

  // Output decode: datapath strobes for the counter, high-time latch, capture and timeout, plus busy.
  always_comb begin
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    hi_load     = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    cap_busy    = (state != IDLE);
    if (WE_disable_cap) begin
      cnt_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clear = 1'b1;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_load = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            hi_load = 1'b1;
            cnt_inc = 1'b1;
          end else if (at_timeout) begin
            timeout_hit = 1'b1;
            cnt_clear   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            capture  = 1'b1;
            cnt_load = 1'b1;
          end else if (at_timeout) begin
            timeout_hit = 1'b1;
            cnt_clear   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // Cycle counter, high-time latch and result registers; results move only on a capture.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt      <= 16'd0;
      hi_tmp   <= 16'd0;
      period_q <= 16'd0;
      impuls_q <= 16'd0;
    end else begin
      if (cnt_clear) begin
        cnt <= 16'd0;
      end else if (cnt_load) begin
        cnt <= 16'd1;
      end else if (cnt_inc && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
      if (hi_load) begin
        hi_tmp <= cnt;
      end
      if (capture) begin
        period_q <= cnt;
        impuls_q <= hi_tmp;
      end
    end
  end

  // Status flags: a capture beats a simultaneous ack, and an ack consumes the
  // old data so the overrun it would have caused is dropped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cap_valid    <= 1'b0;
      cap_overrun  <= 1'b0;
      cap_overflow <= 1'b0;
    end else begin
      if (capture) begin
        cap_valid   <= 1'b1;
        cap_overrun <= RE_ack ? 1'b0 : (cap_overrun | cap_valid);
      end else if (RE_ack) begin
        cap_valid   <= 1'b0;
        cap_overrun <= 1'b0;
      end
      if (timeout_hit) begin
        cap_overflow <= 1'b1;
      end else if (RE_ack) begin
        cap_overflow <= 1'b0;
      end
    end
  end

  assign period_low  = period_q[7:0];
  assign period_high = period_q[15:8];
  assign impuls_low  = impuls_q[7:0];
  assign impuls_high = impuls_q[15:8];

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomised stimulus for pwm_capture.
// The reference model works on the timestamps of the PWM edges the bench
// drives: period is rise-to-rise distance, high time is rise-to-fall distance.

module tb_pwm_capture;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic       WE_enable_cap = 1'b0;
  logic       WE_disable_cap = 1'b0;
  logic       RE_ack = 1'b0;
  logic [7:0] period_low;
  logic [7:0] period_high;
  logic [7:0] impuls_low;
  logic [7:0] impuls_high;
  logic       cap_valid;
  logic       cap_overrun;
  logic       cap_overflow;
  logic       cap_busy;

  int total = 0;
  int bad   = 0;

  // Model state: time in bench steps, line level, arming and edge timestamps.
  int          now = 0;
  logic        cur_pwm = 1'b0;
  bit          armed = 1'b0;
  bit          have_rise = 1'b0;
  int          last_rise = 0;
  int          last_fall = 0;
  int          last_cap = -100;
  logic [15:0] exp_period = 16'd0;
  logic [15:0] exp_impuls = 16'd0;
  logic        exp_valid = 1'b0;
  logic        exp_overrun = 1'b0;
  logic        exp_overflow = 1'b0;
  logic        prev_valid;
  int          h;
  int          l;

  pwm_capture #(.SYNC_STAGES(2), .TIMEOUT(16'hFFFF)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .pwm_in         (pwm_in),
    .WE_enable_cap  (WE_enable_cap),
    .WE_disable_cap (WE_disable_cap),
    .RE_ack         (RE_ack),
    .period_low     (period_low),
    .period_high    (period_high),
    .impuls_low     (impuls_low),
    .impuls_high    (impuls_high),
    .cap_valid      (cap_valid),
    .cap_overrun    (cap_overrun),
    .cap_overflow   (cap_overflow),
    .cap_busy       (cap_busy)
  );

  // Free-running clock.
  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
      now++;
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s at step %0d: got 0x%0h, want 0x%0h", tag, now, obs, exp);
    end
  endtask

  // A line that stays unresolved for more than TIMEOUT cycles after a rise is abandoned.
  task automatic check_all(input string tag);
    if (armed && have_rise && (now - last_rise) >= 65538) begin
      exp_overflow = 1'b1;
      have_rise    = 1'b0;
    end
    check_val({tag, "/period_low"},  {8'h00, period_low},  {8'h00, exp_period[7:0]});
    check_val({tag, "/period_high"}, {8'h00, period_high}, {8'h00, exp_period[15:8]});
    check_val({tag, "/impuls_low"},  {8'h00, impuls_low},  {8'h00, exp_impuls[7:0]});
    check_val({tag, "/impuls_high"}, {8'h00, impuls_high}, {8'h00, exp_impuls[15:8]});
    check_val({tag, "/valid"},    {15'd0, cap_valid},    {15'd0, exp_valid});
    check_val({tag, "/overrun"},  {15'd0, cap_overrun},  {15'd0, exp_overrun});
    check_val({tag, "/overflow"}, {15'd0, cap_overflow}, {15'd0, exp_overflow});
    check_val({tag, "/busy"},     {15'd0, cap_busy},     {15'd0, logic'(armed)});
  endtask

  // Drive the line; on each rise while armed, close the previous period if one is open.
  task automatic set_pwm(input logic v);
    if (v && !cur_pwm) begin
      if (armed) begin
        if (have_rise && (now - last_rise) > 65535) begin
          exp_overflow = 1'b1;
          have_rise    = 1'b0;
        end
        if (have_rise) begin
          exp_overrun = exp_overrun | exp_valid;
          exp_valid   = 1'b1;
          exp_period  = 16'(now - last_rise);
          exp_impuls  = 16'(last_fall - last_rise);
          last_cap    = now;
        end
        have_rise = 1'b1;
        last_rise = now;
      end
    end else if (!v && cur_pwm) begin
      last_fall = now;
    end
    cur_pwm = v;
    pwm_in  = v;
  endtask

  task automatic seg(input logic v, input int n);
    set_pwm(v);
    step(n);
  endtask

  task automatic run_period(input int hi, input int lo);
    seg(1'b1, hi);
    seg(1'b0, lo);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(1);
    Reset        = 1'b0;
    armed        = 1'b0;
    have_rise    = 1'b0;
    last_cap     = -100;
    exp_period   = 16'd0;
    exp_impuls   = 16'd0;
    exp_valid    = 1'b0;
    exp_overrun  = 1'b0;
    exp_overflow = 1'b0;
  endtask

  task automatic pulse_enable();
    WE_enable_cap = 1'b1;
    armed = 1'b1;
    step(1);
    WE_enable_cap = 1'b0;
  endtask

  task automatic pulse_disable();
    WE_disable_cap = 1'b1;
    armed     = 1'b0;
    have_rise = 1'b0;
    step(1);
    WE_disable_cap = 1'b0;
  endtask

  task automatic pulse_both();
    WE_enable_cap  = 1'b1;
    WE_disable_cap = 1'b1;
    armed     = 1'b0;
    have_rise = 1'b0;
    step(1);
    WE_enable_cap  = 1'b0;
    WE_disable_cap = 1'b0;
  endtask

  // An ack landing within two steps of a rise drive meets or precedes that capture,
  // so the new data survives and only the old status is consumed.
  task automatic pulse_ack();
    RE_ack = 1'b1;
    if ((now - last_cap) <= 2) begin
      exp_overrun  = 1'b0;
      exp_overflow = 1'b0;
    end else begin
      exp_valid    = 1'b0;
      exp_overrun  = 1'b0;
      exp_overflow = 1'b0;
    end
    step(1);
    RE_ack = 1'b0;
  endtask

  // Directed sequence with a randomised middle section.
  initial begin
    do_reset();
    check_all("reset");

    // 30 high / 70 low, exact capture latency, then overrun and ack.
    pulse_enable();
    step(3);
    check_all("armed");
    run_period(30, 70);
    prev_valid = exp_valid;
    set_pwm(1'b1);
    step(2);
    check_val("valid_latency", {15'd0, cap_valid}, {15'd0, prev_valid});
    step(1);
    check_all("first_capture");
    seg(1'b1, 27);
    seg(1'b0, 30);
    pulse_enable();
    step(39);
    run_period(30, 70);
    check_all("overrun");
    pulse_ack();
    check_all("after_ack");
    run_period(30, 70);
    check_all("fresh_capture");

    // Random periods with occasional acks.
    for (int i = 0; i < 10; i++) begin
      h = int'($urandom_range(2, 40));
      l = int'($urandom_range(2, 40));
      seg(1'b1, h);
      seg(1'b0, l - 1);
      check_all("rand");
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
      end else begin
        step(1);
      end
    end

    // Stuck-high line times out, then a 5/5 line is measured.
    do_reset();
    check_all("reset2");
    pulse_enable();
    step(3);
    seg(1'b1, 70000);
    check_all("overflow");
    seg(1'b0, 5);
    run_period(5, 5);
    run_period(5, 5);
    check_all("after_overflow");

    // Enable in the middle of a high pulse, then 1/1 toggling.
    pulse_disable();
    step(3);
    seg(1'b1, 4);
    pulse_enable();
    step(4);
    seg(1'b0, 3);
    seg(1'b1, 1);
    seg(1'b0, 4);
    check_all("partial_ignored");
    for (int i = 0; i < 12; i++) begin
      seg(1'b1, 1);
      seg(1'b0, 1);
    end
    step(3);
    check_all("one_one");

    // Simultaneous enable/disable, then disable during the low phase.
    pulse_disable();
    step(2);
    pulse_both();
    step(2);
    check_all("both");
    pulse_enable();
    step(3);
    run_period(6, 8);
    run_period(6, 8);
    check_all("pre_disable");
    seg(1'b1, 6);
    seg(1'b0, 3);
    pulse_disable();
    step(3);
    seg(1'b1, 5);
    seg(1'b0, 5);
    check_all("disabled");

    // Reset in the middle of a high phase, no capture until re-armed.
    pulse_enable();
    step(3);
    run_period(7, 9);
    run_period(7, 9);
    seg(1'b1, 3);
    do_reset();
    check_all("mid_reset");
    seg(1'b0, 4);
    run_period(4, 4);
    run_period(4, 4);
    check_all("no_rearm");

    // Ack arriving on the same edge as a capture.
    pulse_enable();
    step(3);
    run_period(5, 6);
    run_period(9, 4);
    check_all("pre_coincide");
    set_pwm(1'b1);
    step(2);
    pulse_ack();
    seg(1'b1, 6);
    seg(1'b0, 3);
    check_all("ack_vs_capture");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator.
- Samples an external PWM line, measures its period and high time ("impuls") in Clock cycles, and presents coherent 16-bit results as low/high byte pairs to the host bus.
- Reports measurement status: valid, overrun, and timeout/overflow for stuck or too-slow lines.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the pwm_in synchroniser (minimum 2).
- TIMEOUT, 16'hFFFF, counter value at which a measurement is abandoned.

Ports:
- Clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM line to measure.
- WE_enable_cap  input  1  one-cycle strobe: arm capture.
- WE_disable_cap  input  1  one-cycle strobe: stop capture.
- RE_ack  input  1  one-cycle strobe: host has read results; clears status flags.
- period_low  output  8  captured period [7:0].
- period_high  output  8  captured period [15:8].
- impuls_low  output  8  captured high time [7:0].
- impuls_high  output  8  captured high time [15:8].
- cap_valid  output  1  a new result pair is available.
- cap_overrun  output  1  sticky: a result was replaced while cap_valid=1.
- cap_overflow  output  1  sticky: a measurement hit TIMEOUT.
- cap_busy  output  1  state is not IDLE.

Behaviour:
Reset:
- All outputs 0, counter 0, synchroniser 0, state IDLE.
- Reset has priority over every other input, including in mid-measurement.

Input path:
- pwm_in passes through SYNC_STAGES flops, then one delay flop. rise = s & ~s_d; fall = ~s & s_d.
- With SYNC_STAGES=2, results and flags update on the 2nd Clock edge after the edge that first samples the closing rising edge of pwm_in high.

Enable control:
- Disable wins over enable in the same cycle.
- Enable while already armed has no effect.
- Disable goes to IDLE from any state. Results and flags are retained.

States:
- IDLE: counter held at 0. WE_enable_cap -> WAIT_RISE.
- WAIT_RISE: wait for the first rise (partial first pulse discarded). On rise: cnt<=1 -> MEAS_HIGH.
- MEAS_HIGH: cnt<=cnt+1 each cycle. On fall: hi_tmp<=cnt -> MEAS_LOW.
- MEAS_LOW: cnt<=cnt+1.
  - On rise: period<=cnt, impuls<=hi_tmp, cap_valid<=1; if cap_valid was already 1 then cap_overrun<=1; cnt<=1 -> MEAS_HIGH.
  - Back-to-back periods are measured with no gap.

Timeout:
- In MEAS_HIGH or MEAS_LOW, if cnt==TIMEOUT and no edge this cycle: cap_overflow<=1, cnt<=0 -> WAIT_RISE.
- Result registers are unchanged. This covers 0% and 100% duty and lines that are too slow.

Arithmetic:
- 16-bit unsigned; never wraps, because timeout precedes wrap.
- For a stable input high H and low L cycles: impuls=H, period=H+L. Minimum H or L is 1 synchronised cycle.

Coherency:
- All four output bytes change only on the same capture edge. A host reading low then high always sees one pair.

RE_ack:
- Clears cap_valid, cap_overrun and cap_overflow.
- If a capture occurs in the same cycle, the capture wins: cap_valid=1, new data, and cap_overrun is cleared (ack consumed the old data).
- If a timeout occurs in the same cycle, cap_overflow=1.

Test Plan:
- Reset, then enable; pwm_in periodic with 30 high / 70 low cycles -> after the second rising edge, period_high/low=0x00/0x64, impuls=0x00/0x1E, cap_valid=1 two cycles after sampling; cap_busy=1.
- Same stimulus without RE_ack across a second full period -> cap_overrun=1, data unchanged at 0x64/0x1E. RE_ack -> valid and overrun go 0; next period -> valid=1, overrun=0.
- Enable with pwm_in held high for 70000 cycles -> cap_overflow=1 when cnt reaches 0xFFFF, state WAIT_RISE, results still 0. Then apply 5/5 PWM -> period=10, impuls=5.
- Enable mid-high-pulse, then 1 high / 1 low alternating -> first partial pulse ignored; period=2, impuls=1 on every capture.
- WE_enable_cap and WE_disable_cap in the same cycle -> stays IDLE, cap_busy=0. Disable mid-MEAS_LOW -> IDLE, prior results retained, no capture on the next rise.
- Assert Reset for 1 cycle during MEAS_HIGH with cap_valid=1 -> all outputs 0 next cycle, state IDLE; re-enable needed before any capture. RE_ack coincident with a capture -> cap_valid stays 1 with new values.
